// File: rtl/updown_mod_counter_if.sv
// Bundles the control inputs and status outputs of updown_mod_counter.
// The master drives the controls and the slave (the counter) returns the status.
interface updown_mod_counter_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);
  logic              en;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clr_flags;
  logic [WIDTH-1:0]  count;
  logic              wrap;
  logic              ovf_sticky;
  logic              at_max;
  logic              at_min;

  modport master (
    output en, up_down, step, load, load_val, clr_flags,
    input  count, wrap, ovf_sticky, at_max, at_min
  );

  modport slave (
    input  en, up_down, step, load, load_val, clr_flags,
    output count, wrap, ovf_sticky, at_max, at_min
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MOD-1 with variable step, clamped parallel load,
// and either modulo wrap or saturation at the range bounds.
module updown_mod_counter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned MOD    = 200,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned SAT    = 0
) (
  input logic                clk,
  input logic                reset,
  updown_mod_counter_if.slave bus
);

  localparam int unsigned AW = WIDTH + 1;
  localparam logic [AW-1:0]    ModW = AW'(MOD);
  localparam logic [WIDTH-1:0] MaxW = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_d, count_q;
  logic             wrap_d, wrap_q;
  logic             ovf_d, ovf_q;

  // One extra bit so count+step and count+MOD never overflow.
  logic [AW-1:0]    cur_ext, step_ext, load_ext, sum_up;
  logic [WIDTH-1:0] up_wrapped, dn_plain, dn_wrapped;
  logic             up_over, dn_under, load_over;

  always_comb begin
    cur_ext    = {1'b0, count_q};
    step_ext   = AW'(bus.step);
    load_ext   = {1'b0, bus.load_val};
    sum_up     = cur_ext + step_ext;
    up_over    = (sum_up >= ModW);
    dn_under   = (cur_ext < step_ext);
    load_over  = (load_ext >= ModW);
    up_wrapped = WIDTH'(sum_up - ModW);
    dn_plain   = WIDTH'(cur_ext - step_ext);
    dn_wrapped = WIDTH'(cur_ext + ModW - step_ext);
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = load_over ? MaxW : bus.load_val;
    end else if (bus.en) begin
      if (bus.up_down) begin
        if (up_over) begin
          wrap_d  = 1'b1;
          count_d = (SAT != 0) ? MaxW : up_wrapped;
        end else begin
          count_d = sum_up[WIDTH-1:0];
        end
      end else begin
        if (dn_under) begin
          wrap_d  = 1'b1;
          count_d = (SAT != 0) ? '0 : dn_wrapped;
        end else begin
          count_d = dn_plain;
        end
      end
    end
    // A new wrap beats a simultaneous clear.
    ovf_d = wrap_d | (ovf_q & ~bus.clr_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    bus.count      = count_q;
    bus.wrap       = wrap_q;
    bus.ovf_sticky = ovf_q;
    bus.at_max     = (count_q == MaxW);
    bus.at_min     = (count_q == '0);
  end

  count_in_range_a: assert property (@(posedge clk) disable iff (reset) count_q <= MaxW);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Drives a wrapping and a saturating counter with the same stimulus and
// compares both against an integer-arithmetic reference model every cycle.
module tb_updown_mod_counter;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned MOD    = 200;
  localparam int unsigned STEP_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) if0 ();
  updown_mod_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) if1 ();

  updown_mod_counter #(.WIDTH(WIDTH), .MOD(MOD), .STEP_W(STEP_W), .SAT(0)) dut_wrap (
    .clk  (clk),
    .reset(reset),
    .bus  (if0)
  );

  updown_mod_counter #(.WIDTH(WIDTH), .MOD(MOD), .STEP_W(STEP_W), .SAT(1)) dut_sat (
    .clk  (clk),
    .reset(reset),
    .bus  (if1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state, index 0 = wrap mode, 1 = saturate mode.
  int m_cnt [2];
  int m_wrap[2];
  int m_ovf [2];

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_update(input int sat, input bit rst, input bit en, input bit ud,
                              input int st, input bit ld, input int lv, input bit clr);
    int n;
    int w;
    w = 0;
    if (rst) begin
      m_cnt[sat] = 0;
      m_wrap[sat] = 0;
      m_ovf[sat] = 0;
      return;
    end
    if (ld) begin
      m_cnt[sat] = (lv > MOD - 1) ? MOD - 1 : lv;
    end else if (en) begin
      n = ud ? m_cnt[sat] + st : m_cnt[sat] - st;
      if (n > int'(MOD) - 1) begin
        w = 1;
        n = sat ? MOD - 1 : n - MOD;
      end else if (n < 0) begin
        w = 1;
        n = sat ? 0 : n + MOD;
      end
      m_cnt[sat] = n;
    end
    m_wrap[sat] = w;
    m_ovf[sat]  = (w != 0 || (m_ovf[sat] != 0 && !clr)) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("wrap_mode count",  if0.count, m_cnt[0]);
    check("wrap_mode wrap",   if0.wrap, m_wrap[0]);
    check("wrap_mode ovf",    if0.ovf_sticky, m_ovf[0]);
    check("wrap_mode at_max", if0.at_max, (m_cnt[0] == MOD - 1) ? 1 : 0);
    check("wrap_mode at_min", if0.at_min, (m_cnt[0] == 0) ? 1 : 0);
    check("sat_mode count",   if1.count, m_cnt[1]);
    check("sat_mode wrap",    if1.wrap, m_wrap[1]);
    check("sat_mode ovf",     if1.ovf_sticky, m_ovf[1]);
    check("sat_mode at_max",  if1.at_max, (m_cnt[1] == MOD - 1) ? 1 : 0);
    check("sat_mode at_min",  if1.at_min, (m_cnt[1] == 0) ? 1 : 0);
  endtask

  task automatic cyc(input bit rst, input bit en, input bit ud, input int st,
                     input bit ld, input int lv, input bit clr);
    reset         = rst;
    if0.en        = en;          if1.en        = en;
    if0.up_down   = ud;          if1.up_down   = ud;
    if0.step      = STEP_W'(st); if1.step      = STEP_W'(st);
    if0.load      = ld;          if1.load      = ld;
    if0.load_val  = WIDTH'(lv);  if1.load_val  = WIDTH'(lv);
    if0.clr_flags = clr;         if1.clr_flags = clr;
    @(posedge clk);
    model_update(0, rst, en, ud, st, ld, lv, clr);
    model_update(1, rst, en, ud, st, ld, lv, clr);
    #1;
    compare_all();
  endtask

  task automatic do_load(input int lv);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, lv, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_wrap[i] = 0;
      m_ovf[i] = 0;
    end

    // Reset dominates load and enable.
    cyc(1'b1, 1'b1, 1'b1, 3, 1'b1, 100, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 3, 1'b1, 100, 1'b0);
    check("reset count", if0.count, 0);
    check("reset at_min", if0.at_min, 1);

    // Up wrap.
    do_load(198);
    cyc(1'b0, 1'b1, 1'b1, 3, 1'b0, 0, 1'b0);
    check("up_wrap count", if0.count, 1);
    check("up_wrap wrap", if0.wrap, 1);
    check("up_wrap ovf", if0.ovf_sticky, 1);
    check("sat_up count", if1.count, 199);
    cyc(1'b0, 1'b1, 1'b1, 3, 1'b0, 0, 1'b0);
    check("up_next count", if0.count, 4);
    check("up_next wrap", if0.wrap, 0);

    // Down wrap, set-beats-clear, then clear alone.
    do_load(2);
    cyc(1'b0, 1'b1, 1'b0, 5, 1'b0, 0, 1'b0);
    check("down_wrap count", if0.count, 197);
    check("down_wrap wrap", if0.wrap, 1);
    do_load(2);
    cyc(1'b0, 1'b1, 1'b0, 5, 1'b0, 0, 1'b1);
    check("set_beats_clr ovf", if0.ovf_sticky, 1);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    check("clr ovf", if0.ovf_sticky, 0);

    // Saturation bounds.
    do_load(198);
    cyc(1'b0, 1'b1, 1'b1, 5, 1'b0, 0, 1'b0);
    check("sat_hi count", if1.count, 199);
    check("sat_hi wrap", if1.wrap, 1);
    check("sat_hi at_max", if1.at_max, 1);
    do_load(3);
    cyc(1'b0, 1'b1, 1'b0, 7, 1'b0, 0, 1'b0);
    check("sat_lo count", if1.count, 0);
    check("sat_lo wrap", if1.wrap, 1);
    do_load(194);
    cyc(1'b0, 1'b1, 1'b1, 5, 1'b0, 0, 1'b0);
    check("sat_exact count", if1.count, 199);
    check("sat_exact wrap", if1.wrap, 0);

    // Load priority, clamp, zero step.
    cyc(1'b0, 1'b1, 1'b1, 7, 1'b1, 250, 1'b0);
    check("load_clamp count", if0.count, 199);
    check("load_clamp wrap", if0.wrap, 0);
    do_load(50);
    check("load count", if0.count, 50);
    cyc(1'b0, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0);
    check("step0 count", if0.count, 50);
    check("step0 wrap", if0.wrap, 0);

    // Reset in the middle of counting.
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0);
    check("midcount pre", if0.count, 7);
    cyc(1'b1, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0);
    check("midcount reset", if0.count, 0);
    cyc(1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0);
    check("midcount resume1", if0.count, 1);
    cyc(1'b0, 1'b1, 1'b1, 1, 1'b0, 0, 1'b0);
    check("midcount resume2", if0.count, 2);

    // Randomized traffic, biased towards enable so wraps are frequent.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 63) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 15)),
          $urandom_range(0, 7) == 0,
          int'($urandom_range(0, 255)),
          $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter with a programmable modulus, variable step, parallel load, and wrap or saturate mode. It is the general-purpose successor to the fixed-width binary up/down counter. It serves as the timer, index and credit counter for sequential blocks whose count range is not a power of two. All state is registered; status flags are decoded from, or registered alongside, the count.

## Interface

Parameters:
- WIDTH, 8: count width in bits.
- MOD, 200: modulus; count range is 0..MOD-1. Constraint: 2 ≤ MOD ≤ 2^WIDTH.
- STEP_W, 4: step input width. Constraint: 2^STEP_W − 1 < MOD.
- SAT, 0: 0 = modulo wrap, 1 = saturate at 0 / MOD-1.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high reset.
- en, input, 1: count enable.
- up_down, input, 1: 1 = count up, 0 = count down.
- step, input, STEP_W: increment/decrement amount, unsigned.
- load, input, 1: parallel load strobe.
- load_val, input, WIDTH: value to load.
- clr_flags, input, 1: clears ovf_sticky.
- count, output, WIDTH: current count.
- wrap, output, 1: registered one-cycle pulse on a wrap or saturation clamp.
- ovf_sticky, output, 1: set by any wrap pulse, held until cleared.
- at_max, output, 1: count == MOD-1, decoded from the count register.
- at_min, output, 1: count == 0, decoded from the count register.

## Operation

Priority per cycle: reset > load > en > hold.

- **reset:** count=0, wrap=0, ovf_sticky=0.
- **load:**
  - count = min(load_val, MOD-1); load_val ≥ MOD clamps to MOD-1.
  - wrap=0; ovf_sticky unchanged.
  - en is ignored that cycle.
- **en, up, SAT=0:**
  - Sum computed in WIDTH+1 bits: s = count + step.
  - If s ≥ MOD: count = s − MOD, wrap=1. Else count = s.
- **en, down, SAT=0:**
  - If count < step: count = count + MOD − step, wrap=1. Else count = count − step.
- **en, SAT=1:**
  - Up result above MOD-1 gives count = MOD-1, wrap=1.
  - Down result below 0 gives count = 0, wrap=1.
  - Landing exactly on a bound is not a clamp, so wrap=0.
- **step = 0 with en:** count holds, wrap=0.
- **en=0, no load:** count holds, wrap=0.
- **ovf_sticky:**
  - Next value = wrap_next | (ovf_sticky & ~clr_flags).
  - Simultaneous set and clear: set wins.
- All intermediate arithmetic is unsigned, WIDTH+1 bits. No result outside 0..MOD-1 ever reaches count.

## Timing

- Single-cycle latency: inputs sampled at edge N, count/wrap/ovf_sticky valid after edge N.
- at_max/at_min follow count in the same cycle; they are combinational decode of a register only, with no input-to-output combinational path.
- wrap is high for exactly one cycle per wrapping operation. Back-to-back wrapping operations keep it high on consecutive cycles.
- Reset mid-operation takes effect on the next edge regardless of load/en; the first count operation follows the first edge with reset low.
- No handshake; en may toggle every cycle.

## Test plan

Default instance WIDTH=8, MOD=200, STEP_W=4, SAT=0 unless stated.

- **Reset:** hold reset 2 cycles with en=1, load=1 -> count=0, wrap=0, ovf_sticky=0, at_min=1.
- **Up wrap:** load 198, then en=1 up step=3 -> count=1, wrap=1 for one cycle, ovf_sticky=1. Next step=3 -> count=4, wrap=0.
- **Down wrap and flags:**
  - count=2, en=1 down step=5 -> count=197, wrap=1.
  - Then clr_flags=1 together with another wrapping op -> ovf_sticky stays 1.
  - clr_flags alone -> ovf_sticky=0.
- **Saturate (SAT=1):**
  - count=198 up step=5 -> 199, wrap=1, at_max=1.
  - count=3 down step=7 -> 0, wrap=1.
  - count=194 up step=5 -> 199, wrap=0.
- **Load priority and clamp:**
  - load=1, en=1, load_val=250 -> count=199, wrap=0.
  - load_val=50 -> count=50.
  - en=1, step=0 -> count=50.
- **Reset mid-count:** counting up step=1 through 0..10, assert reset at count=7 -> count=0 next edge; deassert -> count 1, 2, … resumes.
